// File: rtl/handshake_sync_pkg.sv
// Shared types and constants for the toggle req/ack CDC handshake.
// Both ends of the handshake import this package.
`timescale 1ns/100ps
package handshake_sync_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } rx_state_e;

    localparam int unsigned SYNC_STAGES_DEFAULT = 32'd2;

    // Both toggle lines leave reset at this level, so equal levels mean "nothing outstanding".
    localparam logic TGL_RESET_LEVEL = 1'b0;

    function automatic logic tgl_pending(input logic req_tgl, input logic ack_tgl);
        return req_tgl ^ ack_tgl;
    endfunction

endpackage

// File: rtl/handshake_sync_rx_if.sv
// Handshake bus seen by the destination end: source toggle/data in, ack back,
// and the downstream valid/ready port with its transfer counter.
`timescale 1ns/100ps
interface handshake_sync_rx_if #(
    parameter int unsigned WIDTH     = 32'd10,
    parameter int unsigned CNT_WIDTH = 32'd16
);
    logic                 i_req_tgl;
    logic [WIDTH-1:0]     i_data;
    logic                 o_ack_tgl;
    logic [WIDTH-1:0]     o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [CNT_WIDTH-1:0] o_xfer_count;

    modport master (
        output i_req_tgl, i_data, i_ready,
        input  o_ack_tgl, o_data, o_valid, o_xfer_count
    );

    modport slave (
        input  i_req_tgl, i_data, i_ready,
        output o_ack_tgl, o_data, o_valid, o_xfer_count
    );
endinterface

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
// Used for the request here and for the acknowledge on the source side.
`timescale 1ns/100ps
module sync_ff_chain
    import handshake_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift chain: stage 0 samples the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_r <= {SYNC_STAGES{TGL_RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_sync_rx.sv
// Destination end of the toggle req/ack handshake: synchronizes the request,
// captures the held source word and acks only once downstream accepts it.
`timescale 1ns/100ps
module handshake_sync_rx
    import handshake_sync_pkg::*;
#(
    parameter int unsigned WIDTH       = 32'd10,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int unsigned CNT_WIDTH   = 32'd16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    handshake_sync_rx_if.slave bus
);

    logic                 req_s;
    logic                 pending_s;
    rx_state_e            state_r;
    rx_state_e            state_s;
    logic [WIDTH-1:0]     data_r;
    logic [WIDTH-1:0]     data_s;
    logic                 valid_r;
    logic                 valid_s;
    logic                 ack_r;
    logic                 ack_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_s;

    // Only the request crosses domains; i_data is held stable by the source while pending.
    sync_ff_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (bus.i_req_tgl),
        .o_sync    (req_s)
    );

    assign pending_s = tgl_pending(req_s, ack_r);

    // Next-state and datapath decode; the ack is withheld while the word waits downstream.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        valid_s = valid_r;
        ack_s   = ack_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (pending_s) begin
                    data_s  = bus.i_data;
                    valid_s = 1'b1;
                    state_s = VALID;
                end else begin
                    state_s = IDLE;
                end
            end
            VALID: begin
                if (valid_r && bus.i_ready) begin
                    valid_s = 1'b0;
                    ack_s   = ~ack_r;
                    count_s = count_r + CNT_WIDTH'(1'b1);
                    state_s = IDLE;
                end else begin
                    state_s = VALID;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; a reset mid-transfer drops the word without acking.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ack_r   <= TGL_RESET_LEVEL;
            count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ack_r   <= ack_s;
            count_r <= count_s;
        end
    end

    assign bus.o_ack_tgl    = ack_r;
    assign bus.o_data       = data_r;
    assign bus.o_valid      = valid_r;
    assign bus.o_xfer_count = count_r;

endmodule

// File: tb/tb_handshake_sync_rx.sv
// Directed bench for handshake_sync_rx: reset, latency, backpressure, reset
// mid-transfer, counter wrap on a 4-bit twin instance, and a two-clock stream.
`timescale 1ns/100ps
module tb_handshake_sync_rx;

    logic clk     = 1'b0;
    logic src_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #29.3 clk = ~clk;
    always #5.0  src_clk = ~src_clk;

    handshake_sync_rx_if #(.WIDTH(10), .CNT_WIDTH(16)) bus ();
    handshake_sync_rx_if #(.WIDTH(10), .CNT_WIDTH(4))  bus_w ();

    // The wrap instance sees exactly the same stimulus as the main one.
    assign bus_w.i_req_tgl = bus.i_req_tgl;
    assign bus_w.i_data    = bus.i_data;
    assign bus_w.i_ready   = bus.i_ready;

    handshake_sync_rx #(.WIDTH(10), .SYNC_STAGES(2), .CNT_WIDTH(16)) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    handshake_sync_rx #(.WIDTH(10), .SYNC_STAGES(2), .CNT_WIDTH(4)) u_dut_w (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_w.slave)
    );

    int   n_vec   = 0;
    int   n_miss  = 0;
    int   got     = 0;
    int   cyc     = 0;
    int   src_k   = 0;
    logic src_tgl = 1'b0;
    logic src_timeout = 1'b0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req_tgl = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input logic exp_ack, input int budget);
        int k;
        k = 0;
        while (bus.o_ack_tgl !== exp_ack && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_vec("ack_seen", 32'(bus.o_ack_tgl), 32'(exp_ack));
    endtask

    initial begin
        bus.i_req_tgl = 1'b0;
        bus.i_data    = 10'h3FF;
        bus.i_ready   = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_valid", 32'(bus.o_valid), 32'd0);
        check_vec("rst_data",  32'(bus.o_data), 32'd0);
        check_vec("rst_ack",   32'(bus.o_ack_tgl), 32'd0);
        check_vec("rst_count", 32'(bus.o_xfer_count), 32'd0);
        check_vec("rst_count_w", 32'(bus_w.o_xfer_count), 32'd0);
        rst_n = 1'b1;

        // Single transfer: valid at t+2, ack at t+3
        @(negedge clk);
        bus.i_data    = 10'h155;
        bus.i_req_tgl = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("single_t1_valid", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check_vec("single_t2_valid", 32'(bus.o_valid), 32'd1);
        check_vec("single_t2_data",  32'(bus.o_data), 32'h155);
        check_vec("single_t2_ack",   32'(bus.o_ack_tgl), 32'd0);
        @(negedge clk);
        check_vec("single_t3_ack",   32'(bus.o_ack_tgl), 32'd1);
        check_vec("single_t3_valid", 32'(bus.o_valid), 32'd0);
        check_vec("single_t3_count", 32'(bus.o_xfer_count), 32'd1);

        // Backpressure for 20 cycles
        apply_reset(2);
        @(negedge clk);
        bus.i_ready   = 1'b0;
        bus.i_data    = 10'h155;
        bus.i_req_tgl = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check_vec("bp_valid", 32'(bus.o_valid), 32'd1);
            check_vec("bp_data",  32'(bus.o_data), 32'h155);
            check_vec("bp_ack",   32'(bus.o_ack_tgl), 32'd0);
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        check_vec("bp_rel_ack",   32'(bus.o_ack_tgl), 32'd1);
        check_vec("bp_rel_valid", 32'(bus.o_valid), 32'd0);
        check_vec("bp_rel_count", 32'(bus.o_xfer_count), 32'd1);
        repeat (3) @(negedge clk);
        check_vec("bp_idle_count", 32'(bus.o_xfer_count), 32'd1);
        check_vec("bp_idle_valid", 32'(bus.o_valid), 32'd0);

        // Reset while holding a word in VALID
        apply_reset(2);
        @(negedge clk);
        bus.i_ready   = 1'b0;
        bus.i_data    = 10'h0AA;
        bus.i_req_tgl = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("mid_pre_valid", 32'(bus.o_valid), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check_vec("mid_rst_ack",   32'(bus.o_ack_tgl), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("mid_redeliver_valid", 32'(bus.o_valid), 32'd1);
        check_vec("mid_redeliver_data",  32'(bus.o_data), 32'h0AA);
        check_vec("mid_redeliver_ack",   32'(bus.o_ack_tgl), 32'd0);
        bus.i_ready = 1'b1;
        @(negedge clk);
        check_vec("mid_accept_ack",   32'(bus.o_ack_tgl), 32'd1);
        check_vec("mid_accept_count", 32'(bus.o_xfer_count), 32'd1);
        repeat (10) @(negedge clk);
        check_vec("mid_no_dup_valid", 32'(bus.o_valid), 32'd0);
        check_vec("mid_no_dup_count", 32'(bus.o_xfer_count), 32'd1);

        // 17 transfers: 4-bit counter wraps to 1
        apply_reset(2);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.i_data    = 10'(i);
            bus.i_req_tgl = ~bus.i_req_tgl;
            wait_ack(bus.i_req_tgl, 20);
        end
        check_vec("wrap_count_w", 32'(bus_w.o_xfer_count), 32'd1);
        check_vec("wrap_count",   32'(bus.o_xfer_count), 32'd17);

        // Stream 0..99 from a 10 ns source into the 58.6 ns destination
        apply_reset(2);
        bus.i_ready = 1'b0;
        src_tgl     = 1'b0;
        fork
            begin
                for (int w = 0; w < 100; w++) begin
                    @(posedge src_clk);
                    bus.i_data = w[9:0];
                    @(posedge src_clk);
                    src_tgl = ~src_tgl;
                    bus.i_req_tgl = src_tgl;
                    src_k = 0;
                    while (bus.o_ack_tgl !== src_tgl && src_k < 500) begin
                        @(posedge src_clk);
                        src_k++;
                    end
                    if (src_k >= 500) begin
                        src_timeout = 1'b1;
                        break;
                    end
                end
            end
            begin
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 4000 && !src_timeout) begin
                    @(negedge clk);
                    cyc++;
                    bus.i_ready = (cyc % 3 != 0);
                    if (bus.o_valid && bus.i_ready) begin
                        check_vec("stream_word", 32'(bus.o_data), 32'(got));
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        check_vec("stream_src_timeout", 32'(src_timeout), 32'd0);
        check_vec("stream_words",   32'(got), 32'd100);
        check_vec("stream_count",   32'(bus.o_xfer_count), 32'd100);
        check_vec("stream_count_w", 32'(bus_w.o_xfer_count), 32'd4);
        repeat (5) @(negedge clk);
        check_vec("stream_tail_valid", 32'(bus.o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
